// File: rtl/sipo_deser_param_if.sv
// Serial line input and word-level valid/ready output bundle for sipo_deser_param.
interface sipo_deser_param_if #(
  parameter int unsigned WORD_W = 10
) ();
  logic              en;
  logic              bit_in;
  logic              bit_valid;
  logic              sync_in;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  en, bit_in, bit_valid, sync_in, out_ready,
    output out_data, out_valid
  );

  modport slave (
    output en, bit_in, bit_valid, sync_in, out_ready,
    input  out_data, out_valid
  );
endinterface

// File: rtl/sipo_deser_param.sv
// Parametrised serial-in/parallel-out deserialiser with optional frame-sync lock
// and a valid/ready holding register on the word side.
module sipo_deser_param #(
  parameter int unsigned WORD_W    = 10,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned SYNC_REQ  = 0,
  parameter int unsigned CNT_W     = $clog2(WORD_W)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sipo_deser_param_if.master   bus,
  output logic                 overrun,
  input  logic                 clr_ovr,
  output logic                 frame_err,
  output logic                 locked,
  output logic [CNT_W-1:0]     bit_cnt
);

  typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

  state_t            state;
  logic [WORD_W-1:0] sr;
  logic [WORD_W-1:0] sr_shift;
  logic              acc;
  logic              resync;
  logic              last_bit;
  logic              word_done;
  logic              drop;

  // Shift/complete decode for the bit accepted this cycle
  always_comb begin
    acc       = bus.en & bus.bit_valid;
    sr_shift  = (MSB_FIRST != 0) ? {sr[WORD_W-2:0], bus.bit_in}
                                 : {bus.bit_in, sr[WORD_W-1:1]};
    resync    = bus.sync_in && (bit_cnt != '0);
    last_bit  = (bit_cnt == CNT_W'(WORD_W - 1));
    word_done = acc && (state == ST_LOCKED) && !resync && last_bit;
    drop      = word_done && bus.out_valid && !bus.out_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= (SYNC_REQ != 0) ? ST_HUNT : ST_LOCKED;
      locked        <= (SYNC_REQ == 0);
      sr            <= '0;
      bit_cnt       <= '0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      if (acc) begin
        case (state)
          ST_HUNT: begin
            if (bus.sync_in) begin
              state   <= ST_LOCKED;
              locked  <= 1'b1;
              sr      <= sr_shift;
              bit_cnt <= CNT_W'(1);
            end
          end
          ST_LOCKED: begin
            sr <= sr_shift;
            if (resync) begin
              // Partial word abandoned; the sync bit restarts the word
              bit_cnt   <= CNT_W'(1);
              frame_err <= 1'b1;
            end else if (last_bit) begin
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          default: state <= ST_LOCKED;
        endcase
      end

      // A completed word replaces an accepted one in the same cycle
      if (word_done && !drop) begin
        bus.out_data  <= sr_shift;
        bus.out_valid <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser_param.sv
// Bench for sipo_deser_param: three configurations driven in parallel and checked
// against a bit-list reference model plus directed expectations.
module tb_sipo_deser_param;
  localparam int unsigned W  = 10;
  localparam int unsigned CW = 4;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic en, bit_in, bit_valid, sync_in, out_ready, clr_ovr;

  always #5 clk = ~clk;

  sipo_deser_param_if #(.WORD_W(W)) bus0 ();
  sipo_deser_param_if #(.WORD_W(W)) bus1 ();
  sipo_deser_param_if #(.WORD_W(W)) bus2 ();

  assign bus0.en = en;  assign bus0.bit_in = bit_in;  assign bus0.bit_valid = bit_valid;
  assign bus0.sync_in = sync_in;  assign bus0.out_ready = out_ready;
  assign bus1.en = en;  assign bus1.bit_in = bit_in;  assign bus1.bit_valid = bit_valid;
  assign bus1.sync_in = sync_in;  assign bus1.out_ready = out_ready;
  assign bus2.en = en;  assign bus2.bit_in = bit_in;  assign bus2.bit_valid = bit_valid;
  assign bus2.sync_in = sync_in;  assign bus2.out_ready = out_ready;

  logic [W-1:0]  o_data [N];
  logic          o_valid[N];
  logic          o_ovr  [N];
  logic          o_ferr [N];
  logic          o_lock [N];
  logic [CW-1:0] o_cnt  [N];

  assign o_data[0] = bus0.out_data;  assign o_valid[0] = bus0.out_valid;
  assign o_data[1] = bus1.out_data;  assign o_valid[1] = bus1.out_valid;
  assign o_data[2] = bus2.out_data;  assign o_valid[2] = bus2.out_valid;

  sipo_deser_param #(.WORD_W(W), .MSB_FIRST(1), .SYNC_REQ(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .overrun(o_ovr[0]), .clr_ovr(clr_ovr),
    .frame_err(o_ferr[0]), .locked(o_lock[0]), .bit_cnt(o_cnt[0]));
  sipo_deser_param #(.WORD_W(W), .MSB_FIRST(0), .SYNC_REQ(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .overrun(o_ovr[1]), .clr_ovr(clr_ovr),
    .frame_err(o_ferr[1]), .locked(o_lock[1]), .bit_cnt(o_cnt[1]));
  sipo_deser_param #(.WORD_W(W), .MSB_FIRST(1), .SYNC_REQ(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .overrun(o_ovr[2]), .clr_ovr(clr_ovr),
    .frame_err(o_ferr[2]), .locked(o_lock[2]), .bit_cnt(o_cnt[2]));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each configuration keeps the list of bits of the current word
  int           m_n    [N];
  bit           m_lock [N];
  bit           m_bits [N][W];
  logic [W-1:0] m_data [N];
  bit           m_valid[N];
  bit           m_ovr  [N];
  bit           m_ferr [N];

  function automatic bit cfg_msb(input int k);
    return k != 1;
  endfunction

  function automatic logic [W-1:0] assemble(input int k);
    logic [W-1:0] w;
    for (int i = 0; i < int'(W); i++) begin
      if (cfg_msb(k)) w[W-1-i] = m_bits[k][i];
      else            w[i]     = m_bits[k][i];
    end
    return w;
  endfunction

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = v[W-1-i];
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit           done;
    logic [W-1:0] w;
    for (int k = 0; k < N; k++) begin
      if (!reset_n) begin
        m_n[k] = 0; m_lock[k] = (k != 2); m_data[k] = '0;
        m_valid[k] = 0; m_ovr[k] = 0; m_ferr[k] = 0;
      end else begin
        done = 0;
        w = '0;
        m_ferr[k] = 0;
        if (en && bit_valid) begin
          if (!m_lock[k]) begin
            if (sync_in) begin
              m_lock[k] = 1; m_bits[k][0] = bit_in; m_n[k] = 1;
            end
          end else if (sync_in && m_n[k] != 0) begin
            m_ferr[k] = 1; m_bits[k][0] = bit_in; m_n[k] = 1;
          end else begin
            m_bits[k][m_n[k]] = bit_in;
            m_n[k]++;
            if (m_n[k] == int'(W)) begin
              done = 1; w = assemble(k); m_n[k] = 0;
            end
          end
        end
        if (clr_ovr) m_ovr[k] = 0;
        if (done) begin
          if (m_valid[k] && !out_ready) m_ovr[k] = 1;
          else begin m_data[k] = w; m_valid[k] = 1; end
        end else if (m_valid[k] && out_ready) begin
          m_valid[k] = 0;
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic s);
    @(negedge clk);
    en = 1'b1; bit_valid = 1'b1; bit_in = b; sync_in = s;
    @(posedge clk); #1;
    bit_valid = 1'b0; sync_in = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] v, input logic s);
    for (int i = 0; i < int'(W); i++) send_bit(v[W-1-i], s && (i == 0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; en = 0; bit_in = 0; bit_valid = 0; sync_in = 0;
    out_ready = 1'b1; clr_ovr = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (o_data[k] !== '0) begin n_bad++; $display("FAIL reset_data[%0d] got %h exp 0", k, o_data[k]); end
      n_cmp++; if (o_valid[k] !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d] got %b exp 0", k, o_valid[k]); end
      n_cmp++; if (o_ovr[k] !== 1'b0) begin n_bad++; $display("FAIL reset_ovr[%0d] got %b exp 0", k, o_ovr[k]); end
      n_cmp++; if (o_ferr[k] !== 1'b0) begin n_bad++; $display("FAIL reset_ferr[%0d] got %b exp 0", k, o_ferr[k]); end
      n_cmp++; if (o_cnt[k] !== '0) begin n_bad++; $display("FAIL reset_cnt[%0d] got %0d exp 0", k, o_cnt[k]); end
      n_cmp++; if (o_lock[k] !== (k != 2)) begin n_bad++; $display("FAIL reset_lock[%0d] got %b exp %b", k, o_lock[k], k != 2); end
    end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_msb_word;
    logic [W-1:0] pat;
    pat = 10'b1011001011;
    out_ready = 1'b1;
    for (int i = 0; i < int'(W); i++) begin
      send_bit(pat[W-1-i], 1'b0);
      if (i == int'(W) - 2) begin
        n_cmp++; if (o_valid[0] !== 1'b0) begin n_bad++; $display("FAIL early_valid got %b exp 0", o_valid[0]); end
      end
    end
    n_cmp++; if (o_valid[0] !== 1'b1) begin n_bad++; $display("FAIL msb_valid got %b exp 1", o_valid[0]); end
    n_cmp++; if (o_data[0] !== 10'b1011001011) begin n_bad++; $display("FAIL msb_data got %b exp 1011001011", o_data[0]); end
    n_cmp++; if (o_cnt[0] !== '0) begin n_bad++; $display("FAIL msb_cnt got %0d exp 0", o_cnt[0]); end
    n_cmp++; if (o_data[1] !== 10'b1101001101) begin n_bad++; $display("FAIL lsb_data got %b exp 1101001101", o_data[1]); end
    n_cmp++; if (o_lock[2] !== 1'b0) begin n_bad++; $display("FAIL hunt_lock got %b exp 0", o_lock[2]); end
    idle(1);
    n_cmp++; if (o_valid[0] !== 1'b0) begin n_bad++; $display("FAIL msb_valid_pulse got %b exp 0", o_valid[0]); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] v;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      v = W'($urandom);
      send_word(v, 1'b0);
      n_cmp++; if (o_data[0] !== v) begin n_bad++; $display("FAIL b2b_msb[%0d] got %h exp %h", j, o_data[0], v); end
      n_cmp++; if (o_data[1] !== rev(v)) begin n_bad++; $display("FAIL b2b_lsb[%0d] got %h exp %h", j, o_data[1], rev(v)); end
      n_cmp++; if (o_valid[1] !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d] got %b exp 1", j, o_valid[1]); end
      n_cmp++; if (o_data[1] !== m_data[1]) begin n_bad++; $display("FAIL b2b_model[%0d] got %h exp %h", j, o_data[1], m_data[1]); end
    end
    n_cmp++; if (o_cnt[1] !== '0) begin n_bad++; $display("FAIL b2b_cnt got %0d exp 0", o_cnt[1]); end
  endtask

  task automatic test_sync;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
    n_cmp++; if (o_lock[2] !== 1'b0) begin n_bad++; $display("FAIL sync_hunt_lock got %b exp 0", o_lock[2]); end
    n_cmp++; if (o_cnt[2] !== '0) begin n_bad++; $display("FAIL sync_hunt_cnt got %0d exp 0", o_cnt[2]); end
    send_word(10'h2A5, 1'b1);
    n_cmp++; if (o_lock[2] !== 1'b1) begin n_bad++; $display("FAIL sync_lock got %b exp 1", o_lock[2]); end
    n_cmp++; if (o_data[2] !== 10'h2A5) begin n_bad++; $display("FAIL sync_data got %h exp 2a5", o_data[2]); end
    n_cmp++; if (o_valid[2] !== 1'b1) begin n_bad++; $display("FAIL sync_valid got %b exp 1", o_valid[2]); end
    n_cmp++; if (o_data[0] !== 10'h2A5) begin n_bad++; $display("FAIL sync_realign got %h exp 2a5", o_data[0]); end
    idle(1);
  endtask

  task automatic test_overrun;
    @(negedge clk) out_ready = 1'b0;
    send_word(10'h155, 1'b1);
    send_word(10'h0AA, 1'b1);
    for (int k = 0; k < N; k += 2) begin
      n_cmp++; if (o_data[k] !== 10'h155) begin n_bad++; $display("FAIL ovr_data[%0d] got %h exp 155", k, o_data[k]); end
      n_cmp++; if (o_ovr[k] !== 1'b1) begin n_bad++; $display("FAIL ovr_set[%0d] got %b exp 1", k, o_ovr[k]); end
      n_cmp++; if (o_valid[k] !== 1'b1) begin n_bad++; $display("FAIL ovr_valid[%0d] got %b exp 1", k, o_valid[k]); end
    end
    @(negedge clk) clr_ovr = 1'b1;
    @(posedge clk); #1;
    clr_ovr = 1'b0;
    n_cmp++; if (o_ovr[0] !== 1'b0) begin n_bad++; $display("FAIL ovr_clr got %b exp 0", o_ovr[0]); end
    n_cmp++; if (o_valid[0] !== 1'b1) begin n_bad++; $display("FAIL ovr_hold got %b exp 1", o_valid[0]); end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (o_valid[0] !== 1'b0) begin n_bad++; $display("FAIL ovr_accept got %b exp 0", o_valid[0]); end
  endtask

  task automatic test_resync;
    logic [W-1:0] v;
    v = 10'h3C6;
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0);
    n_cmp++; if (o_cnt[0] !== 4'd4) begin n_bad++; $display("FAIL resync_pre_cnt got %0d exp 4", o_cnt[0]); end
    n_cmp++; if (o_ferr[0] !== 1'b0) begin n_bad++; $display("FAIL resync_pre_ferr got %b exp 0", o_ferr[0]); end
    for (int i = 0; i < int'(W); i++) begin
      if (i == 5) begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          en = 1'b0; bit_valid = 1'b1; bit_in = 1'($urandom); sync_in = (c == 1);
          @(posedge clk); #1;
        end
        en = 1'b1; bit_valid = 1'b0; sync_in = 1'b0;
        n_cmp++; if (o_cnt[0] !== 4'd5) begin n_bad++; $display("FAIL en_hold_cnt got %0d exp 5", o_cnt[0]); end
        n_cmp++; if (o_valid[0] !== 1'b0) begin n_bad++; $display("FAIL en_hold_valid got %b exp 0", o_valid[0]); end
      end
      send_bit(v[W-1-i], i == 0);
      if (i == 0) begin
        n_cmp++; if (o_ferr[0] !== 1'b1) begin n_bad++; $display("FAIL resync_ferr got %b exp 1", o_ferr[0]); end
        n_cmp++; if (o_cnt[0] !== 4'd1) begin n_bad++; $display("FAIL resync_cnt got %0d exp 1", o_cnt[0]); end
      end else if (i == 1) begin
        n_cmp++; if (o_ferr[0] !== 1'b0) begin n_bad++; $display("FAIL resync_ferr_pulse got %b exp 0", o_ferr[0]); end
      end
    end
    n_cmp++; if (o_data[0] !== v) begin n_bad++; $display("FAIL resync_data got %h exp %h", o_data[0], v); end
    n_cmp++; if (o_valid[0] !== 1'b1) begin n_bad++; $display("FAIL resync_valid got %b exp 1", o_valid[0]); end
    idle(1);
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] v;
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
    n_cmp++; if (o_cnt[0] !== 4'd6) begin n_bad++; $display("FAIL rmid_pre_cnt got %0d exp 6", o_cnt[0]); end
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (o_cnt[0] !== '0) begin n_bad++; $display("FAIL rmid_cnt got %0d exp 0", o_cnt[0]); end
    n_cmp++; if (o_data[0] !== '0) begin n_bad++; $display("FAIL rmid_data got %h exp 0", o_data[0]); end
    n_cmp++; if (o_valid[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b exp 0", o_valid[0]); end
    n_cmp++; if (o_lock[2] !== 1'b0) begin n_bad++; $display("FAIL rmid_lock got %b exp 0", o_lock[2]); end
    @(negedge clk) reset_n = 1'b1;
    v = W'($urandom);
    send_word(v, 1'b1);
    n_cmp++; if (o_data[0] !== v) begin n_bad++; $display("FAIL rmid_next0 got %h exp %h", o_data[0], v); end
    n_cmp++; if (o_data[2] !== v) begin n_bad++; $display("FAIL rmid_next2 got %h exp %h", o_data[2], v); end
    n_cmp++; if (o_valid[2] !== 1'b1) begin n_bad++; $display("FAIL rmid_valid2 got %b exp 1", o_valid[2]); end
  endtask

  task automatic test_random;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      en        = ($urandom_range(0, 9) != 0);
      bit_valid = ($urandom_range(0, 3) != 0);
      bit_in    = 1'($urandom);
      sync_in   = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_ovr   = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        n_cmp++; if (o_data[k] !== m_data[k]) begin n_bad++; $display("FAIL rnd_data[%0d] c=%0d got %h exp %h", k, c, o_data[k], m_data[k]); end
        n_cmp++; if (o_valid[k] !== m_valid[k]) begin n_bad++; $display("FAIL rnd_valid[%0d] c=%0d got %b exp %b", k, c, o_valid[k], m_valid[k]); end
        n_cmp++; if (o_ovr[k] !== m_ovr[k]) begin n_bad++; $display("FAIL rnd_ovr[%0d] c=%0d got %b exp %b", k, c, o_ovr[k], m_ovr[k]); end
        n_cmp++; if (o_ferr[k] !== m_ferr[k]) begin n_bad++; $display("FAIL rnd_ferr[%0d] c=%0d got %b exp %b", k, c, o_ferr[k], m_ferr[k]); end
        n_cmp++; if (o_lock[k] !== m_lock[k]) begin n_bad++; $display("FAIL rnd_lock[%0d] c=%0d got %b exp %b", k, c, o_lock[k], m_lock[k]); end
        n_cmp++; if (o_cnt[k] !== CW'(m_n[k])) begin n_bad++; $display("FAIL rnd_cnt[%0d] c=%0d got %0d exp %0d", k, c, o_cnt[k], m_n[k]); end
      end
    end
    bit_valid = 1'b0; sync_in = 1'b0; clr_ovr = 1'b0;
  endtask

  initial begin
    test_reset;
    test_msb_word;
    test_back_to_back;
    test_sync;
    test_overrun;
    test_resync;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
